multi_bcd_counter: RTL and testbench
====================================

// Module: multi_bcd_counter
// PURPOSE
// - Parametrised N-digit BCD up/down counter; successor to the single-digit BCD stage.
// - Adds a per-cycle step of 0/1/2 (Trigger + Cin), count direction, parallel load and
//   chain carry/borrow out for cascading.
// - Drives display digit data for the seven-segment scan logic on Basys3.
// PARAMETERS
// - NUM_DIGITS   4   number of BCD digits; value range 0 .. 10^NUM_DIGITS-1
// PORTS
// - Clk       in   1             system clock, rising edge
// - Reset     in   1             asynchronous, active-low; clears counter
// - Trigger   in   1             count request; contributes +1 to step
// - Cin       in   1             carry/borrow in from lower stage; contributes +1 to step
// - Up        in   1             1 = count up, 0 = count down
// - Load      in   1             synchronous parallel load
// - LoadData  in   4*NUM_DIGITS  BCD load value, digit 0 in [3:0]
// - DataOut   out  4*NUM_DIGITS  registered BCD count, digit 0 in [3:0]
// - Cout      out  1             combinational carry (up) / borrow (down) out
// BEHAVIOUR
// - Reset=0: DataOut=0 immediately, independent of Clk; Cout=0 while Reset=0.
// - Step = Trigger + Cin (0, 1 or 2), applied on each rising Clk edge.
// - Priority per edge: Load > count. Load=1: DataOut <= LoadData next edge; Trigger/Cin ignored.
// - Load digit clamp: any LoadData digit >9 loads as 9 (e.g. 4'hB -> 4'h9).
// - Up=1: DataOut <= (Value + Step) mod 10^N; digit ripple: digit >9 wraps -10, carries 1.
// - Up=0: DataOut <= (Value - Step) mod 10^N; digit <0 wraps +10, borrows 1.
// - Step=0: DataOut holds.
// - Latency: 1 clock from Trigger/Cin/Load to DataOut.
// - Cout (combinational, same cycle as inputs, Load=0 and Reset=1 only):
//     Up=1: Value + Step > 10^N-1;  Up=0: Value < Step.  Otherwise 0. Load=1 forces Cout=0.
// - Wrap examples (N=4): 9999+1 -> 0000; 9999+2 -> 0001; 9998+2 -> 0000; 0001-2 -> 9999.
// - Up changes take effect on next edge; no state retained across direction change.
// - Reset asserted mid-count or mid-load aborts operation; counting resumes from 0 after
//   Reset released, on first rising edge with Step>0.
// - All DataOut digits always valid BCD (0..9) in every cycle.
// CONFIGURATION
// - BCD_SATURATE_EN defined: no wrap. Up overflow holds at all-9s; down underflow holds
//   at 0; Cout still asserted in the cycle where overflow/underflow is requested.
//   Step=2 from 9998 up -> 9999 with Cout=1.
// - BCD_SATURATE_EN undefined: modulo-10^N wrap as described in BEHAVIOUR.
// TESTING (NUM_DIGITS=4, Clk period 2 ns, check 0.1 ns after edge)
// - Count to 0347, drive Reset=0 between edges -> DataOut=0000 before next edge, Cout=0.
// - Reset=1, Up=1, Trigger=1, Cin=0, 10 edges from 0000 -> 0010; after edge 9 DataOut=0009,
//   Cout=0; edge 10 carries digit0 into digit1.
// - Load 9998, then Trigger=1, Cin=1, Up=1 -> Cout=1 before edge; DataOut=0000 after edge.
// - Load 0001, Up=0, Trigger=1, Cin=1 -> Cout=1; next edge DataOut=9999.
// - LoadData=16'h0A5B, Load=1, Trigger=1 -> DataOut=0959 after one edge, no count applied.
// - BCD_SATURATE_EN: load 9999, Up=1, Trigger=1 for 3 edges -> DataOut stays 9999, Cout=1.

Source files
------------

// File: rtl/multi_bcd_counter.sv
`timescale 1ns/10ps
// multi_bcd_counter: N-digit BCD up/down counter, step 0/1/2 (Trigger + Cin), parallel load
//   with per-digit clamp to 9, chained carry/borrow out for cascading stages.
// Latency: 1 Clk from Trigger/Cin/Load to DataOut; Cout is combinational in the same cycle.
// Backpressure: none; every rising edge applies Load or the step unconditionally.
// Ports:
//   Clk       system clock, rising edge
//   Reset     asynchronous active-low clear; also forces Cout low
//   Trigger   count request, +1 to step
//   Cin       carry/borrow from lower stage, +1 to step
//   Up        1 = count up, 0 = count down
//   Load      synchronous parallel load, wins over counting
//   LoadData  BCD load value, digit 0 in [3:0]; digits >9 load as 9
//   DataOut   registered BCD count, digit 0 in [3:0]
//   Cout      carry (Up) / borrow (down) out; 0 while Load or Reset asserted
// Optional feature: define BCD_SATURATE_EN to clamp at all-9s / 0 instead of wrapping.
module multi_bcd_counter #(
  parameter int NUM_DIGITS = 4
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    Trigger,
  input  logic                    Cin,
  input  logic                    Up,
  input  logic                    Load,
  input  logic [4*NUM_DIGITS-1:0] LoadData,
  output logic [4*NUM_DIGITS-1:0] DataOut,
  output logic                    Cout
);

  localparam int W = 4 * NUM_DIGITS;

  logic [1:0]   step;
  logic [1:0]   ripple;      // step into digit 0, then carry/borrow (0/1) between digits
  logic [4:0]   dig;
  logic [4:0]   sum;
  logic [W-1:0] count_next;
  logic [W-1:0] load_val;
  logic [W-1:0] data_next;
  logic         ovf;         // carry/borrow out of the top digit

  // Digit ripple. A digit is at most 9 and its incoming value at most 2,
  // so a single +/-10 correction always lands back in 0..9.
  always_comb begin
    step       = {1'b0, Trigger} + {1'b0, Cin};
    ripple     = step;
    count_next = '0;
    dig        = '0;
    sum        = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      dig = {1'b0, DataOut[4*i +: 4]};
      if (Up) begin
        sum = dig + {3'b000, ripple};
        if (sum > 5'd9) begin
          sum    = sum - 5'd10;
          ripple = 2'd1;
        end else begin
          ripple = 2'd0;
        end
      end else begin
        if (dig < {3'b000, ripple}) begin
          sum    = dig + 5'd10 - {3'b000, ripple};
          ripple = 2'd1;
        end else begin
          sum    = dig - {3'b000, ripple};
          ripple = 2'd0;
        end
      end
      count_next[4*i +: 4] = sum[3:0];
    end
    ovf = (ripple != 2'd0);
  end

  // Non-BCD load digits are clamped so DataOut never holds an illegal digit.
  always_comb begin
    load_val = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      load_val[4*i +: 4] = (LoadData[4*i +: 4] > 4'd9) ? 4'd9 : LoadData[4*i +: 4];
    end
  end

  always_comb begin
    data_next = count_next;
    if (Load) begin
      data_next = load_val;
    end
`ifdef BCD_SATURATE_EN
    else if (ovf) begin
      data_next = Up ? {NUM_DIGITS{4'h9}} : '0;
    end
`else
    // Wrap: count_next already holds the value modulo 10^NUM_DIGITS.
`endif
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      DataOut <= '0;
    end else begin
      DataOut <= data_next;
    end
  end

  assign Cout = Reset & ~Load & ovf;

endmodule

// File: tb/tb_multi_bcd_counter.sv
`timescale 1ns/10ps
module tb_multi_bcd_counter;

  localparam int N = 4;
  localparam int W = 4 * N;
`ifdef BCD_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic         Clk = 1'b0;
  logic         Reset;
  logic         Trigger;
  logic         Cin;
  logic         Up;
  logic         Load;
  logic [W-1:0] LoadData;
  logic [W-1:0] DataOut;
  logic         Cout;

  int check_cnt = 0;
  int err_cnt   = 0;
  int model_val = 0;   // reference count as a plain integer

  multi_bcd_counter #(.NUM_DIGITS(N)) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .Trigger  (Trigger),
    .Cin      (Cin),
    .Up       (Up),
    .Load     (Load),
    .LoadData (LoadData),
    .DataOut  (DataOut),
    .Cout     (Cout)
  );

  always #1 Clk = ~Clk;

  // ---------------- reference model (integer arithmetic) ----------------
  function automatic int pow10(input int n);
    int r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r = '0;
    int x = v;
    for (int i = 0; i < N; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic int load_value(input logic [W-1:0] ld);
    int r = 0;
    int d;
    for (int i = 0; i < N; i++) begin
      d = int'(ld[4*i +: 4]);
      if (d > 9) d = 9;
      r = r + d * pow10(i);
    end
    return r;
  endfunction

  function automatic int model_next(input int v, input bit t, input bit c, input bit u,
                                    input bit l, input logic [W-1:0] ld);
    int step = int'(t) + int'(c);
    int nv;
    int maxv = pow10(N) - 1;
    if (l) return load_value(ld);
    if (u) begin
      nv = v + step;
      if (nv > maxv) nv = SAT ? maxv : nv - pow10(N);
    end else begin
      nv = v - step;
      if (nv < 0) nv = SAT ? 0 : nv + pow10(N);
    end
    return nv;
  endfunction

  function automatic bit model_cout(input int v, input bit t, input bit c, input bit u,
                                    input bit l);
    int step = int'(t) + int'(c);
    if (l) return 1'b0;
    return u ? (v + step > pow10(N) - 1) : (v < step);
  endfunction

  // ---------------- stimulus primitives ----------------
  // Drive inputs between edges and settle before Cout is sampled.
  task automatic apply(input bit t, input bit c, input bit u, input bit l,
                       input logic [W-1:0] ld);
    Trigger  = t;
    Cin      = c;
    Up       = u;
    Load     = l;
    LoadData = ld;
    #0.2;
  endtask

  // Advance one edge, sample 0.1 ns after it, and advance the model.
  task automatic tick();
    model_val = model_next(model_val, Trigger, Cin, Up, Load, LoadData);
    @(posedge Clk);
    #0.1;
  endtask

  task automatic load_to(input int v);
    apply(1'b0, 1'b0, 1'b1, 1'b1, to_bcd(v));
    tick();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    Reset = 1'b0;
    apply(1'b1, 1'b1, 1'b0, 1'b0, '0);
    @(posedge Clk);
    #0.1;
    check_cnt++;
    if (DataOut !== '0) begin
      err_cnt++;
      $display("FAIL reset_dataout: got %h expected 0000", DataOut);
    end
    check_cnt++;
    if (Cout !== 1'b0) begin
      err_cnt++;
      $display("FAIL reset_cout: got %b expected 0", Cout);
    end
    #0.4;
    Reset = 1'b1;
    model_val = 0;
    apply(1'b0, 1'b0, 1'b1, 1'b0, '0);
    tick();
  endtask

  task automatic test_count_up_carry();
    load_to(0);
    for (int e = 1; e <= 10; e++) begin
      apply(1'b1, 1'b0, 1'b1, 1'b0, '0);
      check_cnt++;
      if (Cout !== 1'b0) begin
        err_cnt++;
        $display("FAIL count_up_cout edge %0d: got %b expected 0", e, Cout);
      end
      tick();
      check_cnt++;
      if (DataOut !== to_bcd(e)) begin
        err_cnt++;
        $display("FAIL count_up edge %0d: got %h expected %h", e, DataOut, to_bcd(e));
      end
    end
  endtask

  task automatic test_wrap_up();
    logic [W-1:0] exp_after;
    exp_after = SAT ? to_bcd(9999) : to_bcd(0);
    load_to(9998);
    apply(1'b1, 1'b1, 1'b1, 1'b0, '0);
    check_cnt++;
    if (Cout !== 1'b1) begin
      err_cnt++;
      $display("FAIL wrap_up_cout: got %b expected 1", Cout);
    end
    tick();
    check_cnt++;
    if (DataOut !== exp_after) begin
      err_cnt++;
      $display("FAIL wrap_up_data: got %h expected %h", DataOut, exp_after);
    end
  endtask

  task automatic test_wrap_down();
    logic [W-1:0] exp_after;
    exp_after = SAT ? to_bcd(0) : to_bcd(9999);
    load_to(1);
    apply(1'b1, 1'b1, 1'b0, 1'b0, '0);
    check_cnt++;
    if (Cout !== 1'b1) begin
      err_cnt++;
      $display("FAIL wrap_down_cout: got %b expected 1", Cout);
    end
    tick();
    check_cnt++;
    if (DataOut !== exp_after) begin
      err_cnt++;
      $display("FAIL wrap_down_data: got %h expected %h", DataOut, exp_after);
    end
  endtask

  task automatic test_load_clamp();
    load_to(9999);
    apply(1'b1, 1'b0, 1'b1, 1'b1, 16'h0A5B);
    check_cnt++;
    if (Cout !== 1'b0) begin
      err_cnt++;
      $display("FAIL load_cout: got %b expected 0 (Load forces 0)", Cout);
    end
    tick();
    check_cnt++;
    if (DataOut !== 16'h0959) begin
      err_cnt++;
      $display("FAIL load_clamp: got %h expected 0959", DataOut);
    end
  endtask

  task automatic test_reset_mid();
    load_to(340);
    for (int e = 0; e < 7; e++) begin
      apply(1'b1, 1'b0, 1'b1, 1'b0, '0);
      tick();
    end
    check_cnt++;
    if (DataOut !== 16'h0347) begin
      err_cnt++;
      $display("FAIL reset_mid_pre: got %h expected 0347", DataOut);
    end
    // Down by 2 from a cleared counter would borrow, so Cout must be held low by Reset.
    apply(1'b1, 1'b1, 1'b0, 1'b0, '0);
    #0.2;
    Reset = 1'b0;
    #0.1;
    model_val = 0;
    check_cnt++;
    if (DataOut !== '0) begin
      err_cnt++;
      $display("FAIL reset_mid_async: got %h expected 0000", DataOut);
    end
    check_cnt++;
    if (Cout !== 1'b0) begin
      err_cnt++;
      $display("FAIL reset_mid_cout: got %b expected 0", Cout);
    end
    @(posedge Clk);
    #0.5;
    Reset = 1'b1;
    apply(1'b1, 1'b0, 1'b1, 1'b0, '0);
    tick();
    check_cnt++;
    if (DataOut !== 16'h0001) begin
      err_cnt++;
      $display("FAIL reset_mid_resume: got %h expected 0001", DataOut);
    end
  endtask

  task automatic test_saturate();
    load_to(9999);
    for (int e = 1; e <= 3; e++) begin
      apply(1'b1, 1'b0, 1'b1, 1'b0, '0);
      check_cnt++;
      if (Cout !== 1'b1) begin
        err_cnt++;
        $display("FAIL saturate_cout edge %0d: got %b expected 1", e, Cout);
      end
      tick();
      check_cnt++;
      if (DataOut !== 16'h9999) begin
        err_cnt++;
        $display("FAIL saturate_hold edge %0d: got %h expected 9999", e, DataOut);
      end
    end
  endtask

  task automatic test_random();
    bit t, c, u, l;
    logic [W-1:0] ld;
    bit exp_c;
    for (int k = 0; k < 400; k++) begin
      t  = 1'($urandom_range(0, 1));
      c  = 1'($urandom_range(0, 1));
      u  = 1'($urandom_range(0, 1));
      l  = ($urandom_range(0, 7) == 0);
      ld = W'($urandom);
      // Bias some cycles toward the wrap boundaries.
      if ($urandom_range(0, 15) == 0) begin
        l  = 1'b1;
        ld = ($urandom_range(0, 1) != 0) ? to_bcd(9998 + int'($urandom_range(0, 1)))
                                         : to_bcd(int'($urandom_range(0, 1)));
      end
      apply(t, c, u, l, ld);
      exp_c = model_cout(model_val, t, c, u, l);
      check_cnt++;
      if (Cout !== exp_c) begin
        err_cnt++;
        $display("FAIL random_cout %0d: got %b expected %b (val %0d)", k, Cout, exp_c, model_val);
      end
      tick();
      check_cnt++;
      if (DataOut !== to_bcd(model_val)) begin
        err_cnt++;
        $display("FAIL random_data %0d: got %h expected %h", k, DataOut, to_bcd(model_val));
      end
    end
  endtask

  initial begin
    Reset    = 1'b0;
    Trigger  = 1'b0;
    Cin      = 1'b0;
    Up       = 1'b1;
    Load     = 1'b0;
    LoadData = '0;
    #0.1;
    test_reset();
    test_count_up_carry();
    test_wrap_up();
    test_wrap_down();
    test_load_clamp();
    test_reset_mid();
    if (SAT) test_saturate();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", check_cnt, err_cnt);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not complete, time %0t expected < 50000", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
